// File: rtl/armleocpu_tlb_pkg.sv
// Shared TLB types: state encodings, entry field widths and the cache entry layout.
// PTE metadata is carried opaquely; its bit meanings come from the existing page-metadata defines.
package armleocpu_tlb_pkg;

  localparam int VPN_W  = 20;
  localparam int PPN_W  = 22;
  localparam int META_W = 8;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_COMPARE_ENC  = 2'd1;
  localparam logic [1:0] ST_PTW_REQ_ENC  = 2'd2;
  localparam logic [1:0] ST_PTW_WAIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_COMPARE  = ST_COMPARE_ENC,
    ST_PTW_REQ  = ST_PTW_REQ_ENC,
    ST_PTW_WAIT = ST_PTW_WAIT_ENC
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
    logic [META_W-1:0] meta;
  } entry_t;

endpackage

// File: rtl/armleocpu_tlb_victim_sel.sv
// Fill index selection: lowest-index invalid entry, else the round-robin pointer,
// which advances only when a fill lands on a full cache.
module armleocpu_tlb_victim_sel #(
  parameter int ENTRIES_W = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(1<<ENTRIES_W)-1:0]     valid_vec,
  input  logic                          fill,
  output logic [ENTRIES_W-1:0]          fill_idx
);

  logic [ENTRIES_W-1:0] rr_q, rr_d;
  logic [ENTRIES_W-1:0] free_idx;
  logic                 any_free;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = (1<<ENTRIES_W) - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        any_free = 1'b1;
        free_idx = i[ENTRIES_W-1:0];
      end
    end
    rr_d = rr_q;
    if (fill && !any_free) begin
      rr_d = rr_q + 1'b1;
    end
    fill_idx = any_free ? free_idx : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/armleocpu_tlb.sv
// Fully-associative TLB in front of the PTW: hit responds in COMPARE, miss walks then fills.
// Optional hit/miss counters under ARMLEOCPU_TLB_STATS_EN; req_ready only in IDLE without invalidate.
module armleocpu_tlb
  import armleocpu_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VPN_W-1:0]  req_vpn,
  output logic              resp_valid,
  output logic [PPN_W-1:0]  resp_ppn,
  output logic [META_W-1:0] resp_metadata,
  output logic              resp_pagefault,
  output logic              resp_accessfault,
  output logic              resp_hit,
  input  logic              invalidate_all,
  output logic              ptw_resolve_request,
  output logic [VPN_W-1:0]  ptw_virtual_address,
  input  logic              ptw_resolve_done,
  input  logic              ptw_resolve_pagefault,
  input  logic              ptw_resolve_accessfault,
  input  logic [META_W-1:0] ptw_resolve_metadata,
  input  logic [PPN_W-1:0]  ptw_resolve_physical_address
`ifdef ARMLEOCPU_TLB_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int N = 1 << ENTRIES_W;

  state_t               state_q, state_d;
  logic [VPN_W-1:0]     vpn_q, vpn_d;
  logic                 fill_kill_q, fill_kill_d;
  entry_t               entries_q [N];
  entry_t               entries_d [N];

  logic                 hit;
  logic [ENTRIES_W-1:0] hit_idx;
  logic                 fill;
  logic [ENTRIES_W-1:0] fill_idx;
  logic [N-1:0]         valid_vec;

  assign ptw_virtual_address = vpn_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      valid_vec[i] = entries_q[i].valid;
    end
  end

  armleocpu_tlb_victim_sel #(
    .ENTRIES_W (ENTRIES_W)
  ) u_victim_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_vec (valid_vec),
    .fill      (fill),
    .fill_idx  (fill_idx)
  );

  // Descending scan: lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (entries_q[i].valid && (entries_q[i].vpn == vpn_q)) begin
        hit     = 1'b1;
        hit_idx = i[ENTRIES_W-1:0];
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    vpn_d               = vpn_q;
    fill_kill_d         = fill_kill_q;
    entries_d           = entries_q;
    fill                = 1'b0;
    req_ready           = 1'b0;
    resp_valid          = 1'b0;
    resp_ppn            = '0;
    resp_metadata       = '0;
    resp_pagefault      = 1'b0;
    resp_accessfault    = 1'b0;
    resp_hit            = 1'b0;
    ptw_resolve_request = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = !invalidate_all;
        if (req_valid && !invalidate_all) begin
          vpn_d   = req_vpn;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit) begin
          resp_valid    = 1'b1;
          resp_hit      = 1'b1;
          resp_ppn      = entries_q[hit_idx].ppn;
          resp_metadata = entries_q[hit_idx].meta;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_PTW_REQ;
        end
      end
      ST_PTW_REQ: begin
        ptw_resolve_request = 1'b1;
        state_d             = ST_PTW_WAIT;
      end
      ST_PTW_WAIT: begin
        if (ptw_resolve_done) begin
          resp_valid       = 1'b1;
          resp_ppn         = ptw_resolve_physical_address;
          resp_metadata    = ptw_resolve_metadata;
          resp_pagefault   = ptw_resolve_pagefault;
          resp_accessfault = ptw_resolve_accessfault;
          state_d          = ST_IDLE;
          fill = !ptw_resolve_pagefault && !ptw_resolve_accessfault &&
                 !fill_kill_q && !invalidate_all;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fill) begin
      entries_d[fill_idx] = '{valid: 1'b1, vpn: vpn_q,
                              ppn: ptw_resolve_physical_address,
                              meta: ptw_resolve_metadata};
    end

    // Flush applies in every state; fills already squashed above.
    if (invalidate_all) begin
      for (int i = 0; i < N; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end

    if (state_d == ST_IDLE) begin
      fill_kill_d = 1'b0;
    end else if (invalidate_all && (state_q != ST_IDLE)) begin
      fill_kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vpn_q       <= '0;
      fill_kill_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vpn_q       <= vpn_d;
      fill_kill_q <= fill_kill_d;
      entries_q   <= entries_d;
    end
  end

`ifdef ARMLEOCPU_TLB_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (state_q == ST_COMPARE) begin
      if (hit) begin
        stat_hits_d = stat_hits_q + 32'd1;
      end else begin
        stat_misses_d = stat_misses_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule
